// File: rtl/cfg_src_arbiter_if.sv
// Bus bundle for cfg_src_arbiter: source selection, SPI/external inputs and
// the registered pixel-matrix outputs. Optional macro: CFG_PARITY_EN adds cfg_parity.
interface cfg_src_arbiter_if #(
  parameter int N_CH  = 2,
  parameter int N_GRP = 4,
  parameter int CFG_W = 6
);
  logic [1:0]             src_sel;
  logic [N_CH-1:0]        shutter_spi;
  logic                   shutter_ext;
  logic [N_CH-1:0]        mode_spi;
  logic                   mode_ext;
  logic [N_CH-1:0]        push_clk_spi;
  logic                   push_clk_ext;
  logic [N_GRP*CFG_W-1:0] cfg_spi;
  logic [1:0]             cfg_ext;
  logic [N_CH-1:0]        shutter;
  logic [N_CH-1:0]        mode;
  logic [N_CH-1:0]        push_clk;
  logic [N_GRP*CFG_W-1:0] cfg_out;
  logic                   src_busy;
`ifdef CFG_PARITY_EN
  logic [N_GRP-1:0]       cfg_parity;

  modport master (
    output src_sel, shutter_spi, shutter_ext, mode_spi, mode_ext,
           push_clk_spi, push_clk_ext, cfg_spi, cfg_ext,
    input  shutter, mode, push_clk, cfg_out, src_busy, cfg_parity
  );
  modport slave (
    input  src_sel, shutter_spi, shutter_ext, mode_spi, mode_ext,
           push_clk_spi, push_clk_ext, cfg_spi, cfg_ext,
    output shutter, mode, push_clk, cfg_out, src_busy, cfg_parity
  );
`else
  modport master (
    output src_sel, shutter_spi, shutter_ext, mode_spi, mode_ext,
           push_clk_spi, push_clk_ext, cfg_spi, cfg_ext,
    input  shutter, mode, push_clk, cfg_out, src_busy
  );
  modport slave (
    input  src_sel, shutter_spi, shutter_ext, mode_spi, mode_ext,
           push_clk_spi, push_clk_ext, cfg_spi, cfg_ext,
    output shutter, mode, push_clk, cfg_out, src_busy
  );
`endif
endinterface

// File: rtl/cfg_src_arbiter.sv
// cfg_src_arbiter: selects/merges SPI and external sources for shutter, mode,
// push_clk and the per-group config word. All outputs registered; push_clk is
// shaped into PUSH_W-cycle pulses; a source switch runs BLANK/SETTLE so the
// pixel matrix never sees a mixed word.
// Optional macro: CFG_PARITY_EN adds registered per-group even parity cfg_parity.
module cfg_src_arbiter #(
  parameter int N_CH   = 2,
  parameter int N_GRP  = 4,
  parameter int CFG_W  = 6,
  parameter int PUSH_W = 4,
  parameter int GUARD  = 8
) (
  input  logic            clk_40MHz,
  input  logic            rst_n,
  cfg_src_arbiter_if.slave bus
);
  localparam int W    = N_GRP * CFG_W;
  localparam int PC_W = $clog2(PUSH_W + 1);
  localparam int GC_W = $clog2(GUARD + 1);

  typedef enum logic [1:0] {RUN, BLANK, SETTLE} state_t;

  state_t          state, state_nx;
  logic [1:0]      active_sel, active_nx, pending_sel, pending_nx;
  logic [GC_W-1:0] cnt, cnt_nx;
  logic [N_CH-1:0] push_spi_prev;
  logic            push_ext_prev;
  logic [N_CH-1:0] edge_v, shutter_nx, mode_nx, push_nx;
  logic [W-1:0]    cfg_nx;
  logic            run_nx;
  logic [PC_W-1:0] pcnt    [N_CH];
  logic [PC_W-1:0] pcnt_nx [N_CH];

  function automatic logic [N_CH-1:0] pick_ch(input logic [1:0] sel,
                                              input logic [N_CH-1:0] spi,
                                              input logic ext);
    case (sel)
      2'b00:   return spi | {N_CH{ext}};
      2'b01:   return spi;
      2'b10:   return {N_CH{ext}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_cfg(input logic [1:0] sel,
                                            input logic [W-1:0] spi,
                                            input logic [1:0] ext);
    logic [W-1:0] rep;
    rep = {N_GRP{{(CFG_W-2){1'b0}}, ext}};
    case (sel)
      2'b00:   return spi | rep;
      2'b01:   return spi;
      2'b10:   return rep;
      default: return '0;
    endcase
  endfunction

  // Switch sequencer: RUN -> BLANK (guard countdown, restart on new request) -> SETTLE -> RUN
  always_comb begin
    state_nx   = state;
    active_nx  = active_sel;
    pending_nx = pending_sel;
    cnt_nx     = cnt;
    case (state)
      RUN: begin
        if (bus.src_sel != active_sel) begin
          state_nx   = BLANK;
          pending_nx = bus.src_sel;
          cnt_nx     = GC_W'(GUARD);
        end
      end
      BLANK: begin
        if (bus.src_sel != pending_sel) begin
          pending_nx = bus.src_sel;
          cnt_nx     = GC_W'(GUARD);
        end else if (cnt == GC_W'(1)) begin
          state_nx  = SETTLE;
          active_nx = pending_sel;
          cnt_nx    = '0;
        end else begin
          cnt_nx = cnt - GC_W'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Next output values: forced low outside RUN, held in freeze, cfg loads only entering SETTLE or in RUN
  always_comb begin
    run_nx     = (state_nx == RUN);
    edge_v     = pick_ch(active_sel, bus.push_clk_spi, bus.push_clk_ext) &
                 ~pick_ch(active_sel, push_spi_prev, push_ext_prev);
    shutter_nx = '0;
    mode_nx    = '0;
    push_nx    = '0;
    cfg_nx     = bus.cfg_out;
    if (run_nx) begin
      if (active_sel == 2'b11) begin
        shutter_nx = bus.shutter;
        mode_nx    = bus.mode;
      end else begin
        shutter_nx = pick_ch(active_sel, bus.shutter_spi, bus.shutter_ext);
        mode_nx    = pick_ch(active_sel, bus.mode_spi, bus.mode_ext);
      end
    end
    if ((state_nx == RUN || state_nx == SETTLE) && active_nx != 2'b11)
      cfg_nx = pick_cfg(active_nx, bus.cfg_spi, bus.cfg_ext);
    for (int i = 0; i < N_CH; i++) begin
      pcnt_nx[i] = '0;
      if (run_nx) begin
        if (pcnt[i] != '0)  pcnt_nx[i] = pcnt[i] - PC_W'(1);
        else if (edge_v[i]) pcnt_nx[i] = PC_W'(PUSH_W);
      end
      push_nx[i] = (pcnt_nx[i] != '0);
    end
  end

  // Sequencer state and busy flag
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      active_sel   <= 2'b00;
      pending_sel  <= 2'b00;
      cnt          <= '0;
      bus.src_busy <= 1'b0;
    end else begin
      state        <= state_nx;
      active_sel   <= active_nx;
      pending_sel  <= pending_nx;
      cnt          <= cnt_nx;
      bus.src_busy <= (state_nx != RUN);
    end
  end

  // Registered outputs and push edge history (history tracks every cycle)
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      bus.shutter   <= '0;
      bus.mode      <= '0;
      bus.push_clk  <= '0;
      bus.cfg_out   <= '0;
      push_spi_prev <= '0;
      push_ext_prev <= 1'b0;
      for (int i = 0; i < N_CH; i++) pcnt[i] <= '0;
    end else begin
      bus.shutter   <= shutter_nx;
      bus.mode      <= mode_nx;
      bus.push_clk  <= push_nx;
      bus.cfg_out   <= cfg_nx;
      push_spi_prev <= bus.push_clk_spi;
      push_ext_prev <= bus.push_clk_ext;
      for (int i = 0; i < N_CH; i++) pcnt[i] <= pcnt_nx[i];
    end
  end

`ifdef CFG_PARITY_EN
  // Even parity per config group, aligned with cfg_out
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      bus.cfg_parity <= '0;
    end else begin
      for (int g = 0; g < N_GRP; g++) bus.cfg_parity[g] <= ^cfg_nx[g*CFG_W +: CFG_W];
    end
  end
`endif

endmodule

// File: tb/tb_cfg_src_arbiter.sv
// Directed testbench for cfg_src_arbiter (default parameters).
`timescale 1ns/1ps
module tb_cfg_src_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cfg_src_arbiter_if #(.N_CH(2), .N_GRP(4), .CFG_W(6)) bus ();

  cfg_src_arbiter #(.N_CH(2), .N_GRP(4), .CFG_W(6), .PUSH_W(4), .GUARD(8)) dut (
    .clk_40MHz (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request sel1; optionally switch to sel2 after after_n busy samples; walk the busy window.
  task automatic run_switch(input logic [1:0] sel1, input int after_n, input logic [1:0] sel2,
                            output int busy_n, output int zero_bad, output int chg, output int chg_at);
    logic [23:0] prev;
    prev = bus.cfg_out;
    busy_n = 0; zero_bad = 0; chg = 0; chg_at = 0;
    bus.src_sel = sel1;
    tick();
    while (bus.src_busy === 1'b1 && busy_n < 40) begin
      busy_n++;
      if ((bus.shutter | bus.mode | bus.push_clk) !== 2'b00) zero_bad++;
      if (bus.cfg_out !== prev) begin
        chg++;
        chg_at = busy_n;
        prev = bus.cfg_out;
      end
      if (busy_n == after_n) bus.src_sel = sel2;
      tick();
    end
  endtask

  initial begin
    int busy_n, zero_bad, chg, chg_at, bad;
    logic [9:0] pv0, pv1;

    rst_n = 1'b0;
    bus.src_sel = 2'b00;
    bus.shutter_spi = '0; bus.shutter_ext = 1'b0;
    bus.mode_spi = '0;    bus.mode_ext = 1'b0;
    bus.push_clk_spi = '0; bus.push_clk_ext = 1'b0;
    bus.cfg_spi = '0;     bus.cfg_ext = '0;
    tick();
    tick();
    chk("rst_shutter", 32'(bus.shutter), 32'h0);
    chk("rst_mode", 32'(bus.mode), 32'h0);
    chk("rst_push", 32'(bus.push_clk), 32'h0);
    chk("rst_cfg", 32'(bus.cfg_out), 32'h0);
    chk("rst_busy", 32'(bus.src_busy), 32'h0);

    // Merge mode
    rst_n = 1'b1;
    bus.cfg_spi = 24'h000041; bus.cfg_ext = 2'b10; bus.shutter_spi = 2'b01;
    tick();
    chk("merge_cfg", 32'(bus.cfg_out), 32'h0820C3);
    chk("merge_shutter", 32'(bus.shutter), 32'h1);
`ifdef CFG_PARITY_EN
    chk("par_000011", 32'(bus.cfg_parity[0]), 32'h0);
`endif
    bus.shutter_ext = 1'b1; bus.mode_spi = 2'b10;
    tick();
    chk("merge_shutter_ext", 32'(bus.shutter), 32'h3);
    chk("merge_mode", 32'(bus.mode), 32'h2);
    bus.shutter_spi = 2'b10; bus.shutter_ext = 1'b0;
    tick();
    chk("latency_shutter", 32'(bus.shutter), 32'h2);

    // 00 -> 01
    run_switch(2'b01, 0, 2'b01, busy_n, zero_bad, chg, chg_at);
    chk("sw1_busy_len", 32'(busy_n), 32'd9);
    chk("sw1_forced_zero", 32'(zero_bad), 32'd0);
    chk("sw1_cfg_changes", 32'(chg), 32'd1);
    chk("sw1_cfg_change_at", 32'(chg_at), 32'd9);
    chk("sw1_cfg", 32'(bus.cfg_out), 32'h000041);
    chk("sw1_shutter", 32'(bus.shutter), 32'h2);

    // Single push edge held high
    bus.push_clk_spi = 2'b01;
    pv0 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pv0[i] = bus.push_clk[0];
    end
    chk("push_single", 32'(pv0), 32'h00F);
    bus.push_clk_spi = 2'b00;
    tick(); tick();

    // Re-edge on ch0 during its pulse, ch1 rises in parallel
    bus.push_clk_spi = 2'b01;
    pv0 = '0; pv1 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pv0[i] = bus.push_clk[0];
      pv1[i] = bus.push_clk[1];
      if (i == 0) bus.push_clk_spi = 2'b00;
      if (i == 1) bus.push_clk_spi = 2'b11;
    end
    chk("push_no_extend_ch0", 32'(pv0), 32'h00F);
    chk("push_ch1", 32'(pv1), 32'h03C);
    bus.push_clk_spi = 2'b00;

    // 01 -> 10 with external push already high
    bus.shutter_spi = 2'b11; bus.mode_spi = 2'b01; bus.shutter_ext = 1'b0; bus.mode_ext = 1'b1;
    bus.cfg_spi = 24'h123456; bus.cfg_ext = 2'b01; bus.push_clk_ext = 1'b1;
    tick();
    chk("spi_cfg", 32'(bus.cfg_out), 32'h123456);
    chk("spi_shutter", 32'(bus.shutter), 32'h3);
    run_switch(2'b10, 0, 2'b10, busy_n, zero_bad, chg, chg_at);
    chk("sw2_busy_len", 32'(busy_n), 32'd9);
    chk("sw2_forced_zero", 32'(zero_bad), 32'd0);
    chk("sw2_cfg_change_at", 32'(chg_at), 32'd9);
    chk("sw2_cfg", 32'(bus.cfg_out), 32'h041041);
    chk("sw2_shutter", 32'(bus.shutter), 32'h0);
    chk("sw2_mode", 32'(bus.mode), 32'h3);
`ifdef CFG_PARITY_EN
    chk("par_000001", 32'(bus.cfg_parity), 32'hF);
`endif
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.push_clk !== 2'b00) bad++;
      tick();
    end
    chk("no_push_on_high_level", 32'(bad), 32'd0);
    bus.push_clk_ext = 1'b0;

    // Nested request inside BLANK: 10 -> 01 -> 00
    bus.cfg_ext = 2'b11; bus.cfg_spi = 24'hFC0000;
    tick();
    chk("ext_cfg", 32'(bus.cfg_out), 32'h0C30C3);
    run_switch(2'b01, 4, 2'b00, busy_n, zero_bad, chg, chg_at);
    chk("nest_busy_len", 32'(busy_n), 32'd13);
    chk("nest_forced_zero", 32'(zero_bad), 32'd0);
    chk("nest_cfg_changes", 32'(chg), 32'd1);
    chk("nest_cfg", 32'(bus.cfg_out), 32'hFC30C3);
    chk("nest_shutter", 32'(bus.shutter), 32'h3);
    chk("nest_mode", 32'(bus.mode), 32'h3);

    // Freeze
    run_switch(2'b11, 0, 2'b11, busy_n, zero_bad, chg, chg_at);
    chk("frz_busy_len", 32'(busy_n), 32'd9);
    chk("frz_cfg_changes", 32'(chg), 32'd0);
    bus.cfg_spi = 24'h000000; bus.push_clk_spi = 2'b11;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.push_clk !== 2'b00) bad++;
    end
    chk("frz_no_push", 32'(bad), 32'd0);
    chk("frz_cfg_hold", 32'(bus.cfg_out), 32'hFC30C3);
    chk("frz_shutter_hold", 32'(bus.shutter), 32'h0);
    bus.push_clk_spi = 2'b00;

    // Async reset in the middle of BLANK
    bus.src_sel = 2'b01;
    tick(); tick(); tick();
    chk("mid_blank_busy", 32'(bus.src_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cfg", 32'(bus.cfg_out), 32'h0);
    chk("async_rst_busy", 32'(bus.src_busy), 32'h0);
    chk("async_rst_out", 32'({bus.shutter, bus.mode, bus.push_clk}), 32'h0);
    bus.src_sel = 2'b00; bus.cfg_spi = 24'h000001; bus.cfg_ext = 2'b10;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_cfg", 32'(bus.cfg_out), 32'h082083);
    tick(); tick();
    chk("post_rst_busy", 32'(bus.src_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
